// File: rtl/if_prefetch.sv
// if_prefetch: instruction-fetch prefetch buffer.
//
// Sits between the core's instruction-ROM port and a variable-latency
// request/acknowledge instruction-memory bus. Sequential words ahead of the
// PC are fetched into a DEPTH-entry FIFO and served combinationally. When
// the PC leaves the sequential stream the FIFO is flushed and refetched; the
// core is stalled until the requested word is present.
//
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   core_ce_i         : core fetch enable (PC chip enable)
//   core_addr_i       : core fetch address (word aligned)
//   core_inst_o       : instruction for core_addr_i, 0 when not valid
//   core_valid_o      : core_inst_o valid this cycle
//   stall_req_o       : core must hold the PC
//   mem_req_o         : memory read request
//   mem_addr_o        : memory read address, held until acknowledged
//   mem_ack_i         : memory acknowledge, mem_data_i valid same cycle
//   mem_data_i        : memory read data
module if_prefetch #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_ce_i,
  input  logic [31:0] core_addr_i,
  output logic [31:0] core_inst_o,
  output logic        core_valid_o,
  output logic        stall_req_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_t;

  state_t        state_q, state_d;

  logic [31:0]   fifo_mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [31:0]   head_addr, fetch_addr, req_addr, issue_addr;

  logic          addr_match, hit, redirect, push, pop, issue;

  // Core-side decode
  assign addr_match = (core_addr_i == head_addr);
  assign hit        = core_ce_i && addr_match && (count != '0);
  assign redirect   = core_ce_i && !addr_match;
  assign pop        = hit;

  // Data acked in a redirect cycle belongs to the old stream and is dropped.
  assign push       = (state_q == REQ) && mem_ack_i && !redirect;

  // Occupancy after this edge; a redirect empties the FIFO.
  assign count_nxt  = redirect ? '0 : (count + CW'(push) - CW'(pop));

  // A redirect issues straight to the new PC so the redirect cycle itself
  // is the only extra cycle when no stale request is in flight.
  assign issue_addr = redirect ? core_addr_i : fetch_addr;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The outstanding request is always retired (acked)
  // whenever issue is evaluated, so the issue rule reduces to count_nxt.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_nxt < CW'(DEPTH)) begin
          issue   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          if (count_nxt < CW'(DEPTH)) begin
            issue   = 1'b1;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end else if (redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req_o    = (state_q != IDLE);
    mem_addr_o   = req_addr;
    core_valid_o = hit;
    core_inst_o  = hit ? fifo_mem[rd_ptr] : '0;
    stall_req_o  = core_ce_i && !hit;
  end

  // Addresses, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_addr  <= '0;
      fetch_addr <= '0;
      req_addr   <= '0;
    end else begin
      count <= count_nxt;

      if (redirect) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        head_addr <= core_addr_i;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr    <= rd_ptr + 1'b1;
          head_addr <= head_addr + 32'd4;
        end
      end

      if (issue) begin
        req_addr   <= issue_addr;
        fetch_addr <= issue_addr + 32'd4;
      end else if (redirect) begin
        fetch_addr <= core_addr_i;
      end
    end
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed, table-driven bench for if_prefetch (DEPTH = 4).
module tb_if_prefetch;

  logic        clk;
  logic        rst;
  logic        core_ce_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_inst_o;
  logic        core_valid_o;
  logic        stall_req_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;

  int unsigned checks;
  int unsigned failures;

  int unsigned wait_cycles;
  int unsigned wcnt;
  logic        prev_req;
  logic        prev_ack;
  logic [31:0] prev_addr;

  typedef struct {
    logic        ce;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] inst;
    logic        stall;
    logic        chk_mem;
    logic        req;
    logic [31:0] maddr;
  } vec_t;

  vec_t zt [10];
  vec_t wt [16];
  vec_t ft [10];

  if_prefetch #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_ce_i    (core_ce_i),
    .core_addr_i  (core_addr_i),
    .core_inst_o  (core_inst_o),
    .core_valid_o (core_valid_o),
    .stall_req_o  (stall_req_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  function automatic vec_t mk(input logic ce, input logic [31:0] pc,
                              input logic valid, input logic stall,
                              input logic chk_mem, input logic req,
                              input logic [31:0] maddr);
    vec_t v;
    v.ce      = ce;
    v.pc      = pc;
    v.valid   = valid;
    v.inst    = valid ? memf(pc) : 32'h0;
    v.stall   = stall;
    v.chk_mem = chk_mem;
    v.req     = req;
    v.maddr   = maddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, answer memory, sample #1 later.
  task automatic step(input logic ce, input logic [31:0] pc);
    @(negedge clk);
    if (prev_req && !prev_ack) begin
      chk("req_held", {31'h0, mem_req_o}, 32'h1);
      chk("addr_held", mem_addr_o, prev_addr);
    end
    core_ce_i   = ce;
    core_addr_i = pc;
    if (mem_req_o) begin
      if (wcnt == wait_cycles) begin
        mem_ack_i  = 1'b1;
        mem_data_i = memf(mem_addr_o);
        wcnt       = 0;
      end else begin
        mem_ack_i  = 1'b0;
        mem_data_i = 32'hDEAD_BEEF;
        wcnt++;
      end
    end else begin
      mem_ack_i  = 1'b0;
      mem_data_i = 32'hDEAD_BEEF;
      wcnt       = 0;
    end
    prev_req  = mem_req_o;
    prev_ack  = mem_ack_i;
    prev_addr = mem_addr_o;
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    step(v.ce, v.pc);
    chk({tag, "_valid"}, {31'h0, core_valid_o}, {31'h0, v.valid});
    chk({tag, "_inst"}, core_inst_o, v.inst);
    chk({tag, "_stall"}, {31'h0, stall_req_o}, {31'h0, v.stall});
    if (v.chk_mem) begin
      chk({tag, "_req"}, {31'h0, mem_req_o}, {31'h0, v.req});
      if (v.req) chk({tag, "_maddr"}, mem_addr_o, v.maddr);
    end
  endtask

  // Asserts reset mid-cycle (checking the asynchronous drop), then releases
  // it at the next falling edge; the first following sample sees REQ at 0.
  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b0;
    core_ce_i   = 1'b0;
    core_addr_i = 32'h0;
    mem_ack_i   = 1'b0;
    mem_data_i  = 32'h0;
    wcnt        = 0;
    prev_req    = 1'b0;
    prev_ack    = 1'b0;
    prev_addr   = 32'h0;
    #1;
    chk("rst_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_maddr", mem_addr_o, 32'h0);
    chk("rst_valid", {31'h0, core_valid_o}, 32'h0);
    chk("rst_inst", core_inst_o, 32'h0);
    chk("rst_stall", {31'h0, stall_req_o}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    core_ce_i   = 1'b0;
    core_addr_i = 32'h0;
    mem_ack_i   = 1'b0;
    mem_data_i  = 32'h0;
    wait_cycles = 0;
    wcnt        = 0;
    prev_req    = 1'b0;
    prev_ack    = 1'b0;
    prev_addr   = 32'h0;

    // Zero-wait streaming: requests 0,4,8,... back to back; word j-1 served
    // at sample j.
    for (int j = 0; j < 10; j++) begin
      if (j == 0) zt[j] = mk(1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
      else        zt[j] = mk(1'b1, 32'(4 * (j - 1)), 1'b1, 1'b0, 1'b1, 1'b1, 32'(4 * j));
    end
    // Three wait cycles: ack on every 4th sample, word available next sample.
    for (int s = 0; s < 16; s++) begin
      logic v;
      logic [31:0] pc;
      v  = (s > 0) && (s % 4 == 0);
      pc = (s <= 4) ? 32'h0 : 32'(4 * ((s - 1) / 4));
      wt[s] = mk(1'b1, pc, v, !v, 1'b1, 1'b1, 32'(4 * (s / 4)));
    end
    // Core idle: exactly four requests fill the FIFO, then none; resume pops.
    for (int s = 0; s < 6; s++) begin
      ft[s] = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, (s < 4), 32'(4 * s));
    end
    ft[6] = mk(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    ft[7] = mk(1'b1, 32'h4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10);
    ft[8] = mk(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    ft[9] = mk(1'b1, 32'hC, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    do_reset();
    wait_cycles = 0;
    for (int i = 0; i < 10; i++) run_vec(zt[i], "zw");

    do_reset();
    wait_cycles = 3;
    for (int i = 0; i < 16; i++) run_vec(wt[i], "ws");

    // Reset lands while a request is pending.
    do_reset();
    wait_cycles = 0;
    for (int i = 0; i < 10; i++) run_vec(ft[i], "full");

    // Redirect to 0x100 while the request for 0x10 is waiting.
    do_reset();
    wait_cycles = 0;
    for (int i = 0; i < 4; i++) run_vec(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'(4 * i)), "rd_fill");
    wait_cycles = 2;
    run_vec(mk(1'b1, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 32'h0),   "rd_a");
    run_vec(mk(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10),  "rd_b");
    run_vec(mk(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10),  "rd_c");
    run_vec(mk(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10),  "rd_d");
    run_vec(mk(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0),   "rd_e");
    run_vec(mk(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100), "rd_f");
    run_vec(mk(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100), "rd_g");
    run_vec(mk(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100), "rd_h");
    run_vec(mk(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0),   "rd_i");

    // Redirect in the same cycle as an ack.
    do_reset();
    wait_cycles = 0;
    run_vec(mk(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0),   "ra_0");
    run_vec(mk(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200), "ra_1");
    run_vec(mk(1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 1'b1, 32'h204), "ra_2");

    // Address wrap from 0xFFFFFFF8.
    do_reset();
    wait_cycles = 0;
    run_vec(mk(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0),          "wr_0");
    run_vec(mk(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8),  "wr_1");
    run_vec(mk(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC),  "wr_2");
    run_vec(mk(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0),          "wr_3");
    run_vec(mk(1'b1, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 32'h4),          "wr_4");
    run_vec(mk(1'b1, 32'h4,         1'b1, 1'b0, 1'b1, 1'b1, 32'h8),          "wr_5");

    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
